// File: rtl/pinball_pkg.sv
// Shared definitions for the pinball ball launch logic: FSM state encoding,
// default tuning constants and the launch speed helper.
package pinball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_CHARGING  = 3'd2,
        ST_LAUNCH    = 3'd3,
        ST_IN_PLAY   = 3'd4,
        ST_LOST      = 3'd5,
        ST_GAME_OVER = 3'd6
    } state_t;

    localparam int DEF_MAX_CHARGE  = 15;
    localparam int DEF_CHARGE_DIV  = 4;
    localparam int DEF_LOST_FRAMES = 60;
    localparam int DEF_INIT_LIFE   = 3;
    localparam int DEF_BASE_SPEED  = 64;
    localparam int DEF_CHARGE_STEP = 16;
    localparam int DEF_LEVEL_STEP  = 8;
    localparam int DEF_MAX_SPEED   = 511;

    // Upward launch speed: magnitude built and capped at 12 bits, then negated.
    function automatic logic [10:0] launch_speed_neg(
        input logic [3:0] charge,
        input logic [3:0] level,
        input int         base_speed,
        input int         charge_step,
        input int         level_step,
        input int         max_speed
    );
        logic [11:0] raw;
        logic [11:0] capped;
        logic [11:0] neg;
        raw = 12'(base_speed) + (12'(charge) * 12'(charge_step))
            + (12'(level) * 12'(level_step));
        if (raw > 12'(max_speed)) begin
            capped = 12'(max_speed);
        end else begin
            capped = raw;
        end
        neg = 12'd0 - capped;
        return neg[10:0];
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Counts qualified frame ticks and flags the tick that completes TERM of them.
// The counter wraps to zero on that tick so it can run continuously.
module frame_tick_counter #(
    parameter int TERM = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic done
);

    localparam int            W      = (TERM > 1) ? $clog2(TERM) : 1;
    localparam logic [W-1:0]  LAST_C = W'(TERM - 1);
    localparam logic [W-1:0]  ZERO_C = W'(1'b0);
    localparam logic [W-1:0]  ONE_C  = W'(1'b1);

    logic [W-1:0] count_r;

    assign done = tick & ~clr & (count_r == LAST_C);

    // Tick counter: clear has priority, wrap on the terminal tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_C;
        end else if (clr) begin
            count_r <= ZERO_C;
        end else if (done) begin
            count_r <= ZERO_C;
        end else if (tick) begin
            count_r <= count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/ball_launch_controller.sv
// Ball launch controller: arms on game start, charges a spring while the
// launch key is held, fires a one-cycle launch pulse with a speed derived from
// charge and level, and tracks lives across ball losses. Outputs are decoded
// from the next state and registered, so they change one cycle after the
// qualifying input.
module ball_launch_controller
    import pinball_pkg::*;
#(
    parameter int MAX_CHARGE  = DEF_MAX_CHARGE,
    parameter int CHARGE_DIV  = DEF_CHARGE_DIV,
    parameter int LOST_FRAMES = DEF_LOST_FRAMES,
    parameter int INIT_LIFE   = DEF_INIT_LIFE,
    parameter int BASE_SPEED  = DEF_BASE_SPEED,
    parameter int CHARGE_STEP = DEF_CHARGE_STEP,
    parameter int LEVEL_STEP  = DEF_LEVEL_STEP,
    parameter int MAX_SPEED   = DEF_MAX_SPEED
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               start,
    input  logic               key5IsPressed,
    input  logic               collisionSmileyBorderBottom,
    input  logic [3:0]         level,
    output logic               launch,
    output logic signed [10:0] launchSpeedY,
    output logic [3:0]         springLevel,
    output logic               ballHold,
    output logic               pause,
    output logic               gameOver,
    output logic [3:0]         life
);

    localparam logic [3:0] MAX_CHARGE_C = 4'(MAX_CHARGE);
    localparam logic [3:0] INIT_LIFE_C  = 4'(INIT_LIFE);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  charge_r;
    logic [3:0]  charge_nxt_s;
    logic [3:0]  life_r;
    logic [3:0]  life_nxt_s;
    logic        start_prev_r;
    logic        start_edge_s;
    logic        launch_r;
    logic [10:0] speed_r;
    logic [10:0] speed_s;
    logic        ball_hold_r;
    logic        pause_r;
    logic        game_over_r;

    logic        div_tick_s;
    logic        div_clr_s;
    logic        div_done_s;
    logic        lost_tick_s;
    logic        lost_clr_s;
    logic        lost_done_s;

    assign start_edge_s = start & ~start_prev_r;
    assign speed_s      = launch_speed_neg(charge_r, level, BASE_SPEED,
                                           CHARGE_STEP, LEVEL_STEP, MAX_SPEED);

    // Release wins over a same-cycle frame pulse because the tick needs the key.
    assign div_tick_s  = startOfFrame & key5IsPressed & (state_r == ST_CHARGING);
    assign div_clr_s   = key5IsPressed & (state_r == ST_ARMED);
    assign lost_tick_s = startOfFrame & (state_r == ST_LOST) & (life_r != 4'd0);
    assign lost_clr_s  = collisionSmileyBorderBottom & (state_r == ST_IN_PLAY);

    frame_tick_counter #(.TERM(CHARGE_DIV)) u_charge_div (
        .clk   (clk),
        .reset (resetN),
        .clr   (div_clr_s),
        .tick  (div_tick_s),
        .done  (div_done_s)
    );

    frame_tick_counter #(.TERM(LOST_FRAMES)) u_lost_delay (
        .clk   (clk),
        .reset (resetN),
        .clr   (lost_clr_s),
        .tick  (lost_tick_s),
        .done  (lost_done_s)
    );

    // Next-state, charge and life update logic.
    always_comb begin
        state_nxt_s  = state_r;
        charge_nxt_s = charge_r;
        life_nxt_s   = life_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    life_nxt_s  = INIT_LIFE_C;
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (key5IsPressed) begin
                    charge_nxt_s = 4'd0;
                    state_nxt_s  = ST_CHARGING;
                end else begin
                    state_nxt_s  = ST_ARMED;
                end
            end
            ST_CHARGING: begin
                if (!key5IsPressed) begin
                    if (charge_r == 4'd0) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_LAUNCH;
                    end
                end else if (div_done_s && (charge_r < MAX_CHARGE_C)) begin
                    charge_nxt_s = charge_r + 4'd1;
                end else begin
                    charge_nxt_s = charge_r;
                end
            end
            ST_LAUNCH: begin
                charge_nxt_s = 4'd0;
                state_nxt_s  = ST_IN_PLAY;
            end
            ST_IN_PLAY: begin
                if (collisionSmileyBorderBottom) begin
                    if (life_r != 4'd0) begin
                        life_nxt_s = life_r - 4'd1;
                    end else begin
                        life_nxt_s = 4'd0;
                    end
                    state_nxt_s = ST_LOST;
                end else begin
                    state_nxt_s = ST_IN_PLAY;
                end
            end
            ST_LOST: begin
                if (life_r == 4'd0) begin
                    state_nxt_s = ST_GAME_OVER;
                end else if (lost_done_s) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_LOST;
                end
            end
            ST_GAME_OVER: begin
                if (start_edge_s) begin
                    life_nxt_s  = INIT_LIFE_C;
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_GAME_OVER;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                charge_nxt_s = 4'd0;
                life_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, datapath and output registers; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_r      <= ST_IDLE;
            charge_r     <= 4'd0;
            life_r       <= 4'd0;
            start_prev_r <= 1'b0;
            launch_r     <= 1'b0;
            speed_r      <= 11'd0;
            ball_hold_r  <= 1'b0;
            pause_r      <= 1'b1;
            game_over_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            charge_r     <= charge_nxt_s;
            life_r       <= life_nxt_s;
            start_prev_r <= start;
            launch_r     <= (state_nxt_s == ST_LAUNCH);
            if ((state_nxt_s == ST_LAUNCH) && (state_r != ST_LAUNCH)) begin
                speed_r <= speed_s;
            end else begin
                speed_r <= speed_r;
            end
            ball_hold_r  <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CHARGING);
            pause_r      <= (state_nxt_s != ST_IN_PLAY) && (state_nxt_s != ST_LAUNCH);
            game_over_r  <= (state_nxt_s == ST_GAME_OVER);
        end
    end

    assign launch       = launch_r;
    assign launchSpeedY = $signed(speed_r);
    assign springLevel  = charge_r;
    assign ballHold     = ball_hold_r;
    assign pause        = pause_r;
    assign gameOver     = game_over_r;
    assign life         = life_r;

endmodule

// File: doc/ball_launch_controller.md
BALL_LAUNCH_CONTROLLER -- requirements
Module: ball_launch_controller

Interface
REQ-001 The block SHALL have parameter MAX_CHARGE, default 15, meaning saturation value of the spring charge counter.
REQ-002 The block SHALL have parameter CHARGE_DIV, default 4, meaning frames per charge step while the key is held.
REQ-003 The block SHALL have parameter LOST_FRAMES, default 60, meaning frames held in LOST before re-arming.
REQ-004 The block SHALL have parameter INIT_LIFE, default 3, meaning life count loaded on game start.
REQ-005 The block SHALL have parameters BASE_SPEED (64), CHARGE_STEP (16), LEVEL_STEP (8) and MAX_SPEED (511), meaning components and cap of the launch speed magnitude.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port resetN, input, 1 bit, meaning reset; it is synchronous and active-high (1 = reset).
REQ-008 The block SHALL have port startOfFrame, input, 1 bit, meaning a one-cycle pulse per video frame.
REQ-009 The block SHALL have port start, input, 1 bit, meaning the game-start request, level sensitive.
REQ-010 The block SHALL have port key5IsPressed, input, 1 bit, meaning the launch key is held.
REQ-011 The block SHALL have port collisionSmileyBorderBottom, input, 1 bit, meaning the ball touched the bottom border.
REQ-012 The block SHALL have port level, input, 4 bits, meaning the current level, unsigned.
REQ-013 The block SHALL have port launch, output, 1 bit, meaning a one-cycle launch pulse.
REQ-014 The block SHALL have port launchSpeedY, output, 11 bits signed, meaning the vertical launch speed, valid while launch=1 and held afterwards.
REQ-015 The block SHALL have port springLevel, output, 4 bits, meaning the current charge for spring drawing.
REQ-016 The block SHALL have ports ballHold, pause and gameOver, outputs, 1 bit each, and life, output, 4 bits.

Function
REQ-017 The FSM SHALL have the states IDLE, ARMED, CHARGING, LAUNCH, IN_PLAY, LOST and GAME_OVER.
REQ-018 In IDLE, start=1 SHALL load life=INIT_LIFE and move the FSM to ARMED on the next cycle.
REQ-019 In ARMED, key5IsPressed=1 SHALL clear the charge and the frame divider and move the FSM to CHARGING.
REQ-020 In CHARGING with the key held, each startOfFrame SHALL advance the divider; when the divider reaches CHARGE_DIV, the charge SHALL increment by 1, saturating at MAX_CHARGE, and the divider SHALL clear.
REQ-021 In CHARGING, key release with charge=0 SHALL return the FSM to ARMED with no launch.
REQ-022 In CHARGING, key release with charge>0 SHALL move the FSM to LAUNCH; release takes priority over a same-cycle startOfFrame, so no increment occurs in that cycle.
REQ-023 LAUNCH SHALL last exactly one cycle with launch=1 and launchSpeedY = -min(BASE_SPEED + charge*CHARGE_STEP + level*LEVEL_STEP, MAX_SPEED), computed at 12-bit unsigned width before negation; the next state is IN_PLAY and the charge clears.
REQ-024 In IN_PLAY, collisionSmileyBorderBottom=1 SHALL decrement life (floor 0) and move the FSM to LOST; bottom collisions in any other state SHALL be ignored.
REQ-025 In LOST, if life=0 the FSM SHALL go to GAME_OVER on the next cycle; otherwise it SHALL count LOST_FRAMES startOfFrame pulses and then go to ARMED.
REQ-026 In GAME_OVER, gameOver=1; a 0->1 edge on start SHALL reload life and move the FSM to ARMED, while start held high continuously from entry SHALL not restart the game.
REQ-027 Output decoding: pause=1 in every state except IN_PLAY and LAUNCH; ballHold=1 in ARMED and CHARGING; springLevel=charge.
REQ-028 All outputs SHALL be registered, with a latency of one cycle from the qualifying input to the output change.

Reset
REQ-029 While resetN=1, the next edge SHALL set state=IDLE, charge=0, dividers=0, life=0, launch=0, launchSpeedY=0, gameOver=0, ballHold=0, pause=1 and the start-edge register=0, from any state including mid-CHARGING and mid-LOST.

Structure
REQ-030 The state enum and the default constants SHALL live in the shared package pinball_pkg.
REQ-031 The design SHALL include one sub-module, frame_tick_counter (a startOfFrame-qualified counter with clear and terminal-count output), instantiated once for the charge divider and once for the LOST delay.

Verification
REQ-032 The bench SHALL cover: start=1 in IDLE -> life=3, ARMED, ballHold=1.
REQ-033 The bench SHALL cover: key held 8 frames then released, level=0 -> exactly one launch pulse, launchSpeedY=-96, IN_PLAY, pause=0.
REQ-034 The bench SHALL cover: key held 100 frames, level=15 -> springLevel=15, launchSpeedY=-min(64+240+120, 511)=-424.
REQ-035 The bench SHALL cover: key released after 2 frames -> no launch, ARMED.
REQ-036 The bench SHALL cover: 3 bottom collisions, each followed by a wait of 60 frames -> life 2,1,0, then GAME_OVER; a held start does not restart, and a start edge gives life=3.
REQ-037 The bench SHALL cover: resetN=1 mid-CHARGING with charge=7 -> next cycle IDLE, springLevel=0, pause=1.
